// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultMH,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic            FlushM,
  input  logic            StallM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] RdM,
  output logic [3:0]      controlM
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_taken;
  logic [3:0]      w_control;

  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_rd;
  logic [3:0]      r_control;

  // Forwarding muxes; select 11 falls back to the register-file value.
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultMH;
      default: w_src_a = RD1E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2E;
    case (ForwardBE)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = ALUResultMH;
      default: w_fwd_b = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;

  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      3'b101:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      3'b110:  w_alu_result = w_src_a << w_src_b[4:0];
      3'b111:  w_alu_result = w_src_a >> w_src_b[4:0];
      default: w_alu_result = '0;
    endcase
  end

  // Branch compare always uses the forwarded register operand, never the immediate.
  always_comb begin
    w_taken = 1'b0;
    case (Funct3E)
      3'b000:  w_taken = (w_src_a == w_fwd_b);
      3'b001:  w_taken = (w_src_a != w_fwd_b);
      3'b100:  w_taken = ($signed(w_src_a) <  $signed(w_fwd_b));
      3'b101:  w_taken = ($signed(w_src_a) >= $signed(w_fwd_b));
      3'b110:  w_taken = (w_src_a <  w_fwd_b);
      3'b111:  w_taken = (w_src_a >= w_fwd_b);
      default: w_taken = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & w_taken);
  assign PCTargetE = JalrE ? (w_alu_result & ~{{(XLEN-1){1'b0}}, 1'b1}) : (PCE + ImmExtE);
  assign w_control = {RegWriteE, ResultSrcE, MemWriteE};

  // Flush outranks stall so a squashed store or register write never survives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
      r_control    <= 4'b0000;
    end else if (FlushM) begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= '0;
      r_control    <= 4'b0000;
    end else if (StallM) begin
      r_alu_result <= r_alu_result;
      r_write_data <= r_write_data;
      r_pc_plus4   <= r_pc_plus4;
      r_rd         <= r_rd;
      r_control    <= r_control;
    end else begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= {{(XLEN-5){1'b0}}, RdE};
      r_control    <= w_control;
    end
  end

  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign RdM        = r_rd;
  assign controlM   = r_control;

endmodule
